// File: rtl/nv_pkg.sv
// ---------------------------------------------------------------------------
// nv_pkg
// Shared types and constants for the EAROM / NVRAM bridge.
//   nv_state_t        : bridge session state (IDLE, DL, UL, DRAIN)
//   NV_INDEX_DEFAULT  : ioctl_index that addresses the NVRAM image
//   NV_FILL           : byte returned for upload reads past the end of the RAM
// ---------------------------------------------------------------------------
package nv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DL    = 2'd1,
        UL    = 2'd2,
        DRAIN = 2'd3
    } nv_state_t;

    localparam logic [7:0] NV_INDEX_DEFAULT = 8'd3;
    localparam logic [7:0] NV_FILL          = 8'hFF;

endpackage

// File: rtl/dpram_nv.sv
// ---------------------------------------------------------------------------
// dpram_nv
// 2**AW x 8 true dual-port RAM, single clock, registered read outputs,
// read-before-write on each port. Only the read registers are reset; the
// array keeps its contents across reset like the non-volatile part it models.
// Ports:
//   clk_25                  clock
//   RESET_L                 synchronous active-low reset (read registers only)
//   addr_a/din_a/we_a       port A address, write data, write enable
//   dout_a                  port A registered read data
//   addr_b/din_b/we_b       port B address, write data, write enable
//   dout_b                  port B registered read data
// Both ports must never write the same address in the same cycle.
// ---------------------------------------------------------------------------
module dpram_nv #(
    parameter int AW = 6
) (
    input  logic          clk_25,
    input  logic          RESET_L,
    input  logic [AW-1:0] addr_a,
    input  logic [7:0]    din_a,
    input  logic          we_a,
    output logic [7:0]    dout_a,
    input  logic [AW-1:0] addr_b,
    input  logic [7:0]    din_b,
    input  logic          we_b,
    output logic [7:0]    dout_b
);

    logic [7:0] mem [2**AW];

    // NOTE: the array has no reset branch on purpose -- resetting a memory
    // prevents block-RAM inference and would erase the saved scores.
    always_ff @(posedge clk_25) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
    end

    // NOTE: non-blocking reads see the pre-write contents, which is what
    // gives read-before-write on both ports (and across ports).
    always_ff @(posedge clk_25) begin
        if (!RESET_L) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            dout_a <= mem[addr_a];
            dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/earom_nvram_bridge.sv
// ---------------------------------------------------------------------------
// earom_nvram_bridge
// High-score store for the Atari vector cores (ER2055 EAROM, 64x8). The game
// CPU owns RAM port A; the hps_io ioctl bus owns port B for NVRAM save
// (upload, core -> HPS) and restore (download, HPS -> core).
// Ports:
//   clk_25, RESET_L                       clock, synchronous active-low reset
//   cpu_addr/cpu_din/cpu_wr               CPU EAROM access
//   cpu_dout                              CPU read data, 1 cycle after cpu_addr
//   ioctl_download/upload/index           HPS session control
//   ioctl_addr/ioctl_wr/ioctl_dout        HPS download byte stream
//   ioctl_rd/ioctl_din                    HPS upload request / data (2-cycle)
//   nv_dirty                              CPU changed RAM since last save/restore
//   nv_busy                               a session (or drain) is in progress
//   nv_lost                               sticky: a deferred CPU write was dropped
// ---------------------------------------------------------------------------
module earom_nvram_bridge
    import nv_pkg::*;
#(
    parameter int         AW       = 6,
    parameter logic [7:0] NV_INDEX = NV_INDEX_DEFAULT
) (
    input  logic          clk_25,
    input  logic          RESET_L,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_wr,
    output logic [7:0]    cpu_dout,
    input  logic          ioctl_download,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic [24:0]   ioctl_addr,
    input  logic          ioctl_wr,
    input  logic [7:0]    ioctl_dout,
    input  logic          ioctl_rd,
    output logic [7:0]    ioctl_din,
    output logic          nv_dirty,
    output logic          nv_busy,
    output logic          nv_lost
);

    nv_state_t     state, state_nxt;
    logic          sess_dl, sess_ul, hps_in_range;

    // Pending CPU write held back while the HPS restores the image.
    logic          pend_valid;
    logic [AW-1:0] pend_addr;
    logic [7:0]    pend_data;

    // RAM port controls.
    logic          we_a, we_b;
    logic [AW-1:0] addr_b;
    logic [7:0]    din_b;
    logic [7:0]    ram_q_b;

    logic          pend_apply, dirty_set, dirty_clr;

    // Upload read pipeline, stage 1 (stage 2 is ioctl_din itself).
    logic          rd_v1, rd_oob1, rd_hit;

    assign sess_dl      = ioctl_download && (ioctl_index == NV_INDEX);
    assign sess_ul      = ioctl_upload   && (ioctl_index == NV_INDEX);
    assign hps_in_range = (ioctl_addr[24:AW] == '0);
    assign rd_hit       = (state == UL) && sess_ul && ioctl_rd;
    assign nv_busy      = (state != IDLE);

    always_ff @(posedge clk_25) begin
        if (!RESET_L) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        we_a       = 1'b0;
        we_b       = 1'b0;
        addr_b     = ioctl_addr[AW-1:0];
        din_b      = ioctl_dout;
        pend_apply = 1'b0;
        dirty_clr  = 1'b0;

        unique case (state)
            IDLE: begin
                if      (sess_dl) state_nxt = DL;
                else if (sess_ul) state_nxt = UL;
                we_a = cpu_wr;
                // Leftover entry from a DRAIN-cycle write. A fresh CPU write to
                // the same byte is newer, so the stale entry is simply dropped.
                if (pend_valid && !(cpu_wr && (cpu_addr == pend_addr))) begin
                    we_b       = 1'b1;
                    addr_b     = pend_addr;
                    din_b      = pend_data;
                    pend_apply = 1'b1;
                end
            end
            DL: begin
                we_b = ioctl_wr && sess_dl && hps_in_range;
                if (!sess_dl) begin
                    state_nxt = DRAIN;
                    dirty_clr = 1'b1;
                end
            end
            UL: begin
                we_a = cpu_wr;
                if (!sess_ul) begin
                    state_nxt = IDLE;
                    dirty_clr = 1'b1;
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
                if (pend_valid) begin
                    we_b       = 1'b1;
                    addr_b     = pend_addr;
                    din_b      = pend_data;
                    pend_apply = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dirty_set = we_a || pend_apply;

    dpram_nv #(.AW(AW)) u_ram (
        .clk_25  (clk_25),
        .RESET_L (RESET_L),
        .addr_a  (cpu_addr),
        .din_a   (cpu_din),
        .we_a    (we_a && RESET_L),
        .dout_a  (cpu_dout),
        .addr_b  (addr_b),
        .din_b   (din_b),
        .we_b    (we_b && RESET_L),
        .dout_b  (ram_q_b)
    );

    // Pending buffer and lost flag.
    always_ff @(posedge clk_25) begin
        if (!RESET_L) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            nv_lost    <= 1'b0;
        end else begin
            unique case (state)
                DL: begin
                    if (cpu_wr) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= cpu_addr;
                        pend_data  <= cpu_din;
                        if (pend_valid) nv_lost <= 1'b1;
                    end
                end
                DRAIN: begin
                    // The old entry drains this cycle, so the slot is free.
                    pend_valid <= cpu_wr;
                    pend_addr  <= cpu_addr;
                    pend_data  <= cpu_din;
                end
                default: pend_valid <= 1'b0;
            endcase
        end
    end

    // Dirty flag: a write in the same cycle as a save/restore boundary wins.
    always_ff @(posedge clk_25) begin
        if (!RESET_L)       nv_dirty <= 1'b0;
        else if (dirty_set) nv_dirty <= 1'b1;
        else if (dirty_clr) nv_dirty <= 1'b0;
    end

    // Upload pipeline: RAM read register is stage 1, ioctl_din is stage 2.
    always_ff @(posedge clk_25) begin
        if (!RESET_L) begin
            rd_v1     <= 1'b0;
            rd_oob1   <= 1'b0;
            ioctl_din <= '0;
        end else begin
            rd_v1   <= rd_hit;
            rd_oob1 <= !hps_in_range;
            if (rd_v1) ioctl_din <= rd_oob1 ? NV_FILL : ram_q_b;
        end
    end

endmodule

// File: tb/tb_earom_nvram_bridge.sv
// ---------------------------------------------------------------------------
// tb_earom_nvram_bridge
// Directed self-checking bench for earom_nvram_bridge. Inputs change 1 ns
// after the rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_earom_nvram_bridge;

    localparam int AW = 6;

    logic          clk_25 = 1'b0;
    logic          RESET_L;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_wr;
    logic [7:0]    cpu_dout;
    logic          ioctl_download, ioctl_upload;
    logic [7:0]    ioctl_index;
    logic [24:0]   ioctl_addr;
    logic          ioctl_wr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_rd;
    logic [7:0]    ioctl_din;
    logic          nv_dirty, nv_busy, nv_lost;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #20 clk_25 = ~clk_25;

    earom_nvram_bridge #(.AW(AW), .NV_INDEX(8'd3)) dut (
        .clk_25         (clk_25),
        .RESET_L        (RESET_L),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_wr         (cpu_wr),
        .cpu_dout       (cpu_dout),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_rd       (ioctl_rd),
        .ioctl_din      (ioctl_din),
        .nv_dirty       (nv_dirty),
        .nv_busy        (nv_busy),
        .nv_lost        (nv_lost)
    );

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_din  = d;
        cpu_wr   = 1'b1;
        tick();
        cpu_wr   = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, output logic [7:0] d);
        cpu_addr = a;
        tick();
        d = cpu_dout;
    endtask

    task automatic hps_write(input int a, input logic [7:0] d);
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic expect8(input string name, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
        else             pass_cnt++;
    endtask

    task automatic expect1(input string name, input logic got, input logic exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %b, expected %b", name, got, exp);
        else             pass_cnt++;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        cpu_write(6'd5, 8'h42);
        expect1("reset_pre_dirty", nv_dirty, 1'b1);
        RESET_L = 1'b0;
        tick();
        expect8("reset_cpu_dout", cpu_dout, 8'h00);
        expect8("reset_ioctl_din", ioctl_din, 8'h00);
        expect1("reset_dirty", nv_dirty, 1'b0);
        expect1("reset_busy", nv_busy, 1'b0);
        expect1("reset_lost", nv_lost, 1'b0);
        RESET_L = 1'b1;
        cpu_read(6'd5, d);
        expect8("reset_ram_kept", d, 8'h42);
    endtask

    task automatic test_upload();
        logic [7:0] prev = 8'h00;
        logic [7:0] exp;
        for (int i = 0; i < 64; i++) cpu_write(AW'(i), 8'(i) ^ 8'hA5);
        expect1("ul_pre_dirty", nv_dirty, 1'b1);
        ioctl_index  = 8'd3;
        ioctl_upload = 1'b1;
        tick();
        expect1("ul_busy", nv_busy, 1'b1);
        for (int i = 0; i <= 64; i++) begin
            exp = (i < 64) ? (8'(i) ^ 8'hA5) : 8'hFF;
            ioctl_addr = 25'(i);
            ioctl_rd   = 1'b1;
            tick();
            ioctl_rd   = 1'b0;
            expect8($sformatf("ul_hold_%0d", i), ioctl_din, prev);
            tick();
            expect8($sformatf("ul_data_%0d", i), ioctl_din, exp);
            prev = exp;
        end
        ioctl_upload = 1'b0;
        tick();
        expect1("ul_exit_dirty", nv_dirty, 1'b0);
        expect1("ul_exit_busy", nv_busy, 1'b0);
        expect8("ul_din_held", ioctl_din, 8'hFF);
    endtask

    task automatic test_download_deferred();
        logic [7:0] d;
        ioctl_index    = 8'd3;
        ioctl_download = 1'b1;
        tick();
        expect1("dl_busy", nv_busy, 1'b1);
        cpu_write(6'd7, 8'h99);
        hps_write(7, 8'h11);
        cpu_read(6'd7, d);
        expect8("dl_ram7_restored", d, 8'h11);
        ioctl_download = 1'b0;
        tick();
        expect1("dl_drain_busy", nv_busy, 1'b1);
        expect1("dl_drain_dirty_clr", nv_dirty, 1'b0);
        tick();
        expect1("dl_idle_busy", nv_busy, 1'b0);
        expect1("dl_dirty", nv_dirty, 1'b1);
        expect1("dl_lost", nv_lost, 1'b0);
        cpu_read(6'd7, d);
        expect8("dl_ram7_cpu_wins", d, 8'h99);
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        ioctl_index    = 8'd3;
        ioctl_download = 1'b1;
        tick();
        cpu_write(6'd1, 8'h01);
        expect1("ovf_lost_one", nv_lost, 1'b0);
        cpu_write(6'd2, 8'h02);
        expect1("ovf_lost", nv_lost, 1'b1);
        hps_write(1, 8'h5A);
        hps_write(2, 8'h6B);
        hps_write(70, 8'h77);
        ioctl_download = 1'b0;
        tick();
        tick();
        cpu_read(6'd2, d);
        expect8("ovf_ram2", d, 8'h02);
        cpu_read(6'd1, d);
        expect8("ovf_ram1", d, 8'h5A);
        cpu_read(6'd6, d);
        expect8("ovf_oob_ignored", d, 8'h06 ^ 8'hA5);
        expect1("ovf_lost_sticky", nv_lost, 1'b1);
    endtask

    task automatic test_drain_write();
        logic [7:0] d;
        ioctl_index    = 8'd3;
        ioctl_download = 1'b1;
        tick();
        ioctl_download = 1'b0;
        tick();
        expect1("drw_in_drain", nv_busy, 1'b1);
        cpu_write(6'd12, 8'hC1);
        cpu_read(6'd12, d);
        expect8("drw_not_yet", d, 8'h0C ^ 8'hA5);
        cpu_read(6'd12, d);
        expect8("drw_applied", d, 8'hC1);
        expect1("drw_dirty", nv_dirty, 1'b1);
    endtask

    task automatic test_index_abort();
        logic [7:0] d;
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        hps_write(3, 8'hEE);
        expect1("idx_busy", nv_busy, 1'b0);
        ioctl_download = 1'b0;
        cpu_read(6'd3, d);
        expect8("idx_ram3", d, 8'h03 ^ 8'hA5);
        ioctl_index    = 8'd3;
        ioctl_download = 1'b1;
        tick();
        expect1("abort_busy_dl", nv_busy, 1'b1);
        hps_write(3, 8'h33);
        cpu_write(6'd4, 8'h44);
        RESET_L        = 1'b0;
        ioctl_download = 1'b0;
        tick();
        RESET_L = 1'b1;
        expect1("abort_busy", nv_busy, 1'b0);
        expect1("abort_lost", nv_lost, 1'b0);
        expect1("abort_dirty", nv_dirty, 1'b0);
        tick();
        tick();
        cpu_read(6'd3, d);
        expect8("abort_ram3", d, 8'h33);
        cpu_read(6'd4, d);
        expect8("abort_pend_dropped", d, 8'h04 ^ 8'hA5);
        expect1("abort_dirty_after", nv_dirty, 1'b0);
    endtask

    task automatic test_collision();
        logic [7:0] d;
        cpu_write(6'd9, 8'h10);
        ioctl_index  = 8'd3;
        ioctl_upload = 1'b1;
        tick();
        cpu_addr   = 6'd9;
        cpu_din    = 8'h20;
        cpu_wr     = 1'b1;
        ioctl_addr = 25'd9;
        ioctl_rd   = 1'b1;
        tick();
        cpu_wr   = 1'b0;
        ioctl_rd = 1'b0;
        tick();
        expect8("col_hps_old", ioctl_din, 8'h10);
        cpu_read(6'd9, d);
        expect8("col_ram9_new", d, 8'h20);
        ioctl_upload = 1'b0;
        cpu_write(6'd10, 8'h55);
        expect1("col_exit_busy", nv_busy, 1'b0);
        expect1("col_exit_dirty", nv_dirty, 1'b1);
        cpu_read(6'd10, d);
        expect8("col_ram10", d, 8'h55);
    endtask

    initial begin
        RESET_L        = 1'b0;
        cpu_addr       = '0;
        cpu_din        = '0;
        cpu_wr         = 1'b0;
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        ioctl_index    = '0;
        ioctl_addr     = '0;
        ioctl_wr       = 1'b0;
        ioctl_dout     = '0;
        ioctl_rd       = 1'b0;
        tick();
        tick();
        RESET_L = 1'b1;
        tick();

        test_reset();
        test_upload();
        test_download_deferred();
        test_overflow();
        test_drain_write();
        test_index_abort();
        test_collision();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
